// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: XLEN, FSM encoding,
// reset NOP and the buffered-entry layout.
package ifetch_pkg;

  localparam int MXLEN = 32;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_BUSY = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0]      word;
    logic [MXLEN-1:0] pc;
    logic             fault;
  } ibuf_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry instruction buffer. The head entry is kept in its own register
// so the decoder-facing outputs hold their last value once the buffer empties.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RST_NOP = INSN_NOP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [31:0]      i_word,
  input  logic [MXLEN-1:0] i_pc,
  input  logic             i_fault,
  output logic [1:0]       o_count,
  output logic [31:0]      o_word,
  output logic [MXLEN-1:0] o_pc,
  output logic             o_fault
);

  ibuf_entry_t r_mem [2];
  ibuf_entry_t r_head;
  ibuf_entry_t w_in;
  ibuf_entry_t w_head_nxt;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;
  logic        w_rd_nxt;
  logic [1:0]  w_cnt_nxt;
  logic        w_head_load;

  // Clear cancels any same-cycle push or pop; pop is ignored when empty.
  always_comb begin
    w_in        = '{word: i_word, pc: i_pc, fault: i_fault};
    w_push      = i_push & ~i_clear;
    w_pop       = i_pop & ~i_clear & (r_count != 2'd0);
    w_rd_nxt    = w_pop ? ~r_rd_ptr : r_rd_ptr;
    w_cnt_nxt   = r_count + {1'b0, w_push} - {1'b0, w_pop};
    // Next head is the incoming word when it lands in the slot the read
    // pointer will be on, otherwise the stored entry at that slot.
    w_head_nxt  = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_in : r_mem[w_rd_nxt];
    w_head_load = ~i_clear & (w_cnt_nxt != 2'd0);
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_cnt_nxt;
    end
  end

  // Storage write; data slots carry no reset.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  // Registered head entry, held while the buffer is empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head <= '{word: RST_NOP, pc: '0, fault: 1'b0};
    end else if (w_head_load) begin
      r_head <= w_head_nxt;
    end
  end

  assign o_count = r_count;
  assign o_word  = r_head.word;
  assign o_pc    = r_head.pc;
  assign o_fault = r_head.fault;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding request/grant/response read at a time,
// results queued in a 2-entry buffer, flush drops everything in flight.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned IBUF_DEPTH = 2,
  parameter logic [31:0] RST_NOP    = INSN_NOP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [MXLEN-1:0] pc_val,
  output logic             pc_advance,
  input  logic             flush,
  output logic             imem_req,
  output logic [MXLEN-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_err,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [MXLEN-1:0] instr_pc,
  output logic             instr_fault,
  input  logic             instr_ready
);

  if_state_e        r_state;
  if_state_e        w_state_nxt;
  logic [MXLEN-1:0] r_req_pc;
  logic [1:0]       w_count;
  logic             w_req;
  logic             w_adv;
  logic             w_push;
  logic             w_pop;

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IF_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and request gating. A request is only raised from IDLE with a
  // free buffer slot, so the single outstanding response always fits.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_adv       = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IF_IDLE: begin
        w_req = ~RST & ~flush & (w_count < 2'(IBUF_DEPTH));
        if (w_req && imem_gnt) begin
          w_adv       = 1'b1;
          w_state_nxt = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (flush) begin
          w_state_nxt = imem_rvalid ? IF_IDLE : IF_DROP;
        end else if (imem_rvalid) begin
          w_push      = 1'b1;
          w_state_nxt = IF_IDLE;
        end
      end
      IF_DROP: begin
        if (imem_rvalid) w_state_nxt = IF_IDLE;
      end
      default: w_state_nxt = IF_IDLE;
    endcase
  end

  // Address of the outstanding request, tagged onto its response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        r_req_pc <= '0;
    else if (w_adv) r_req_pc <= pc_val;
  end

  assign w_pop = instr_valid & instr_ready;

  ifetch_buf #(
    .RST_NOP (RST_NOP)
  ) u_buf (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_word  (imem_rdata),
    .i_pc    (r_req_pc),
    .i_fault (imem_err),
    .o_count (w_count),
    .o_word  (instr),
    .o_pc    (instr_pc),
    .o_fault (instr_fault)
  );

  assign instr_valid = (w_count != 2'd0);
  assign imem_req    = w_req;
  assign pc_advance  = w_adv;
  assign imem_addr   = pc_val;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: memory responder model, PC-unit model and a scoreboard
// of expected buffer entries pushed on each grant.
module tb_ifetch;

  logic        CLK;
  logic        RST;
  logic [31:0] pc_val;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        instr_ready;

  ifetch dut (
    .CLK         (CLK),
    .RST         (RST),
    .pc_val      (pc_val),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .instr_ready (instr_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        gnt;
    logic        flush;
    logic        exp_req;
    logic        exp_adv;
    logic [31:0] exp_addr;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[10];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          pend = 0;
  bit          live = 0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          resp_delay = 1;
  bit          err_en = 0;
  logic [31:0] err_addr = '0;
  bit          found;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: scoreboard sampling mid-cycle, then memory and PC models
  // update just after the rising edge.
  task automatic tick();
    exp_t e;
    logic adv_s;
    int   inflight;
    #2;
    inflight = (live && (pend || imem_rvalid)) ? 1 : 0;
    chk("instr_valid", instr_valid, (exp_q.size() > inflight));
    if (flush) begin
      exp_q.delete();
      live = 0;
    end else if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_when_nothing_expected", instr_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("head_entry", {instr, instr_pc, instr_fault}, e);
      end
    end
    if (imem_req && imem_gnt) begin
      e.word  = word_of(imem_addr);
      e.pc    = imem_addr;
      e.fault = err_en && (imem_addr == err_addr);
      exp_q.push_back(e);
      pend      = 1;
      live      = 1;
      pend_addr = imem_addr;
      pend_cnt  = resp_delay;
    end
    adv_s = pc_advance;
    @(posedge CLK);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_err    = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(pend_addr);
        imem_err    = err_en && (pend_addr == err_addr);
        pend        = 0;
      end else begin
        pend_cnt--;
      end
    end
    if (adv_s) pc_val = pc_val + 32'd4;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    flush = 1'b0;
    exp_q.delete();
    pend = 0;
    live = 0;
    imem_rvalid = 1'b0;
    imem_err = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_head(input logic [31:0] pc, output bit ok);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (instr_valid && instr_pc == pc) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h40};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h40};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h40};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h40};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h40};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h44};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h44};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h48};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h48};

    RST = 1'b1; flush = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;
    pc_val = '0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
    @(posedge CLK);
    #2;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_pc_advance", pc_advance, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_fault", instr_fault, 1'b0);
    tick();

    // Free-running memory after reset release
    RST = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    #1;
    chk("t1_first_adv", pc_advance, 1'b1);
    chk("t1_first_addr", imem_addr, 32'h0);
    tick();
    #1;
    chk("t1_adv_gap", pc_advance, 1'b0);
    chk("t1_valid_not_yet", instr_valid, 1'b0);
    tick();
    #1;
    chk("t1_valid_rise", instr_valid, 1'b1);
    chk("t1_head_pc0", instr_pc, 32'h0);
    chk("t1_second_adv", pc_advance, 1'b1);
    repeat (8) tick();

    // Decoder stalled
    pc_val = 32'h0; resp_delay = 1;
    do_reset();
    instr_ready = 1'b0; imem_gnt = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_req_held_low", imem_req, 1'b0);
      chk("t2_head_pc0", instr_pc, 32'h0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    #1;
    chk("t2_head_pc4", instr_pc, 32'h4);
    chk("t2_resume_adv", pc_advance, 1'b1);
    repeat (6) tick();
    chk("t2_fetch_resumed", (pc_val >= 32'd16), 1'b1);

    // Flush while BUSY, response 3 cycles after grant
    pc_val = 32'h0; resp_delay = 3;
    do_reset();
    instr_ready = 1'b1; imem_gnt = 1'b1;
    tick();
    flush = 1'b1;
    #1;
    chk("t3_flush_req", imem_req, 1'b0);
    chk("t3_flush_adv", pc_advance, 1'b0);
    tick();
    flush = 1'b0; pc_val = 32'h100;
    #1;
    chk("t3_drop_req", imem_req, 1'b0);
    tick();
    #1;
    chk("t3_drop_rvalid_req", imem_req, 1'b0);
    chk("t3_drop_valid", instr_valid, 1'b0);
    tick();
    #1;
    chk("t3_redirect_req", imem_req, 1'b1);
    chk("t3_redirect_addr", imem_addr, 32'h100);
    chk("t3_redirect_adv", pc_advance, 1'b1);
    chk("t3_still_empty", instr_valid, 1'b0);
    repeat (6) tick();

    // Flush coinciding with rvalid, pop and gnt
    pc_val = 32'h0; resp_delay = 1;
    do_reset();
    instr_ready = 1'b0; imem_gnt = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b1; flush = 1'b1;
    #1;
    chk("t4_rvalid_present", imem_rvalid, 1'b1);
    chk("t4_valid_before", instr_valid, 1'b1);
    chk("t4_no_adv", pc_advance, 1'b0);
    chk("t4_no_req", imem_req, 1'b0);
    tick();
    flush = 1'b0; pc_val = 32'h200;
    #1;
    chk("t4_empty_after", instr_valid, 1'b0);
    chk("t4_idle_req", imem_req, 1'b1);
    chk("t4_new_addr", imem_addr, 32'h200);
    tick();
    tick();
    #1;
    chk("t4_redirect_head", {instr_valid, instr_pc}, {1'b1, 32'h200});
    repeat (4) tick();

    // Access fault on pc 0x8
    pc_val = 32'h0; resp_delay = 1; err_en = 1; err_addr = 32'h8;
    do_reset();
    instr_ready = 1'b1; imem_gnt = 1'b1;
    wait_head(32'h8, found);
    chk("t5_found_pc8", found, 1'b1);
    chk("t5_fault_pc8", instr_fault, 1'b1);
    tick();
    wait_head(32'hC, found);
    chk("t5_found_pcC", found, 1'b1);
    chk("t5_fault_pcC", instr_fault, 1'b0);
    tick();
    err_en = 0;
    repeat (2) tick();

    // Grant withheld, then request/flush sequence from a vector table
    pc_val = 32'h40; resp_delay = 1;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_gnt = vecs[i].gnt;
      flush    = vecs[i].flush;
      #1;
      chk($sformatf("t6_req[%0d]", i), imem_req, vecs[i].exp_req);
      chk($sformatf("t6_adv[%0d]", i), pc_advance, vecs[i].exp_adv);
      chk($sformatf("t6_addr[%0d]", i), imem_addr, vecs[i].exp_addr);
      tick();
    end
    flush = 1'b0; imem_gnt = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
